// File: rtl/instr_fetch.sv
// Instruction fetch stage for the Lab3 MIPS CPU.
// Holds the PC, requests words from instruction memory with a req/ack
// handshake (with timeout and retry), presents each word to the decoder with
// valid/ready, and computes the next PC when the decoder retires the word.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (trap on misaligned next PC).
module instr_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic [1:0]  jSel,
   input  logic [1:0]  pcSel,
   input  logic [15:0] imm,
   input  logic [25:0] jump_addr,
   input  logic [31:0] rs_data,
   input  logic        alu_zero,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_fault
);

   localparam int             CNT_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

`ifdef IFETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {FETCH, WAIT, ISSUE, TRAP} fetchState_t;
`else
   typedef enum logic [1:0] {FETCH, WAIT, ISSUE} fetchState_t;
`endif

   fetchState_t      state;
   fetchState_t      stateNext;
   logic [31:0]      pcReg;
   logic [31:0]      pcNext;
   logic [31:0]      instrReg;
   logic [31:0]      instrNext;
   logic             validReg;
   logic             validNext;
   logic [CNT_W-1:0] retryCnt;
   logic [CNT_W-1:0] retryCntNext;
   logic             active;
   logic [31:0]      pcPlus4;
   logic [31:0]      brTgt;
   logic             brTaken;
   logic [31:0]      rawTarget;
   logic             inGap;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic             faultReg;
   logic             faultNext;
`endif

   assign pcPlus4 = pcReg + 32'd4;
   assign brTgt   = pcPlus4 + {{14{imm[15]}}, imm, 2'b00};
   assign inGap   = (state == WAIT) && (retryCnt == CNT_MAX);

   // The stage is held idle for the first edge after reset so that fetching
   // starts cleanly at RESET_PC and imem_req stays low during reset.
   assign imem_req    = active && ((state == FETCH) || ((state == WAIT) && !inGap));
   assign imem_addr   = pcReg;
   assign instr       = instrReg;
   assign instr_valid = validReg;
   assign pc          = pcReg;
   assign pc_plus4    = pcPlus4;
`ifdef IFETCH_MISALIGN_TRAP_EN
   assign fetch_fault = faultReg;
`else
   assign fetch_fault = 1'b0;
`endif

   // Select the raw next PC from the decoder controls; illegal encodings fall back to sequential.
   always_comb begin
      brTaken   = 1'b0;
      rawTarget = pcPlus4;
      case (pcSel)
         2'd1:    brTaken = alu_zero;
         2'd2:    brTaken = !alu_zero;
         default: brTaken = 1'b0;
      endcase
      case (jSel)
         2'd0:    rawTarget = rs_data;
         2'd1:    rawTarget = {pcPlus4[31:28], jump_addr, 2'b00};
         2'd2:    rawTarget = brTaken ? brTgt : pcPlus4;
         default: rawTarget = pcPlus4;
      endcase
   end

   // Next-state and datapath update logic for the fetch FSM.
   always_comb begin
      stateNext    = state;
      pcNext       = pcReg;
      instrNext    = instrReg;
      validNext    = validReg;
      retryCntNext = retryCnt;
`ifdef IFETCH_MISALIGN_TRAP_EN
      faultNext    = faultReg;
`endif
      if (active) begin
         case (state)
            FETCH: begin
               retryCntNext = '0;
               if (imem_ack) begin
                  instrNext = imem_rdata;
                  validNext = 1'b1;
                  stateNext = ISSUE;
               end else begin
                  stateNext = WAIT;
               end
            end
            WAIT: begin
               if (inGap) begin
                  retryCntNext = '0;
                  stateNext    = FETCH;
               end else if (imem_ack) begin
                  instrNext    = imem_rdata;
                  validNext    = 1'b1;
                  retryCntNext = '0;
                  stateNext    = ISSUE;
               end else begin
                  retryCntNext = retryCnt + 1'b1;
               end
            end
            ISSUE: begin
               if (instr_ready) begin
                  validNext = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
                  pcNext = rawTarget;
                  if (rawTarget[1:0] != 2'b00) begin
                     faultNext = 1'b1;
                     stateNext = TRAP;
                  end else begin
                     stateNext = FETCH;
                  end
`else
                  pcNext    = rawTarget & 32'hFFFF_FFFC;
                  stateNext = FETCH;
`endif
               end
            end
            default: begin
               stateNext = state;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         pcReg    <= RESET_PC;
         instrReg <= 32'd0;
         validReg <= 1'b0;
         retryCnt <= '0;
         active   <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
         faultReg <= 1'b0;
`endif
      end else begin
         state    <= stateNext;
         pcReg    <= pcNext;
         instrReg <= instrNext;
         validReg <= validNext;
         retryCnt <= retryCntNext;
         active   <= 1'b1;
`ifdef IFETCH_MISALIGN_TRAP_EN
         faultReg <= faultNext;
`endif
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table of next-PC vectors plus
// hand-written sequences for reset, stall, timeout/retry and misaligned targets.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [1:0]  jSel;
   logic [1:0]  pcSel;
   logic [15:0] imm;
   logic [25:0] jump_addr;
   logic [31:0] rs_data;
   logic        alu_zero;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_fault;

   int checks   = 0;
   int failures = 0;
   logic [31:0] dataSeed = 32'hA500_0000;

   typedef struct {
      logic [31:0] startPc;
      logic [1:0]  jSel;
      logic [1:0]  pcSel;
      logic [15:0] imm;
      logic [25:0] jumpAddr;
      logic [31:0] rsData;
      logic        aluZero;
      logic [31:0] expPc;
   } vec_t;

   vec_t vecs[10];

   instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .jSel(jSel), .pcSel(pcSel), .imm(imm), .jump_addr(jump_addr),
      .rs_data(rs_data), .alu_zero(alu_zero),
      .pc(pc), .pc_plus4(pc_plus4), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Wait (bounded) for a request, check its address, ack in the following cycle.
   task automatic serveFetch(input logic [31:0] expAddr);
      logic found;
      logic [31:0] data;
      found = 1'b0;
      data = dataSeed;
      dataSeed = dataSeed + 32'h0001_0011;
      for (int i = 0; i < 40; i++) begin
         if (imem_req) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("reqSeen", {31'd0, found}, 32'd1);
      checkOutput("fetchAddr", imem_addr, expAddr);
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_ack   = 1'b0;
      checkOutput("instrValid", {31'd0, instr_valid}, 32'd1);
      checkOutput("instr", instr, data);
   endtask

   // Drive decoder outputs and retire the current instruction for one cycle.
   task automatic applyStimulus(input logic [1:0] js, input logic [1:0] ps, input logic [15:0] im,
                                input logic [25:0] ja, input logic [31:0] rs, input logic az);
      jSel        = js;
      pcSel       = ps;
      imm         = im;
      jump_addr   = ja;
      rs_data     = rs;
      alu_zero    = az;
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      jSel        = 2'd2;
      pcSel       = 2'd0;
   endtask

   initial begin
      logic [31:0] heldInstr;
      logic [31:0] curPc;

      vecs[0] = '{32'h0000_0040, 2'd2, 2'd1, 16'hFFFE, 26'd0, 32'd0, 1'b1, 32'h0000_003C};
      vecs[1] = '{32'h0000_0040, 2'd2, 2'd1, 16'hFFFE, 26'd0, 32'd0, 1'b0, 32'h0000_0044};
      vecs[2] = '{32'h0000_0040, 2'd2, 2'd2, 16'hFFFE, 26'd0, 32'd0, 1'b0, 32'h0000_003C};
      vecs[3] = '{32'h0000_0040, 2'd2, 2'd2, 16'hFFFE, 26'd0, 32'd0, 1'b1, 32'h0000_0044};
      vecs[4] = '{32'h1000_0010, 2'd1, 2'd0, 16'h0000, 26'h0000040, 32'd0, 1'b0, 32'h1000_0100};
      vecs[5] = '{32'h0000_0040, 2'd0, 2'd0, 16'h0000, 26'd0, 32'h0000_0200, 1'b0, 32'h0000_0200};
      vecs[6] = '{32'h0000_0080, 2'd3, 2'd1, 16'h0010, 26'h3FFFFFF, 32'h0000_0300, 1'b1, 32'h0000_0084};
      vecs[7] = '{32'h0000_0080, 2'd2, 2'd3, 16'h0010, 26'd0, 32'd0, 1'b1, 32'h0000_0084};
      vecs[8] = '{32'hFFFF_FFFC, 2'd2, 2'd0, 16'h0000, 26'd0, 32'd0, 1'b0, 32'h0000_0000};
      vecs[9] = '{32'h0000_0100, 2'd2, 2'd1, 16'h0010, 26'd0, 32'd0, 1'b1, 32'h0000_0144};

      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
      jSel = 2'd2; pcSel = 2'd0; imm = 16'd0; jump_addr = 26'd0; rs_data = 32'd0; alu_zero = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("rstPc", pc, 32'd0);
      checkOutput("rstInstr", instr, 32'd0);
      checkOutput("rstValid", {31'd0, instr_valid}, 32'd0);
      checkOutput("rstReq", {31'd0, imem_req}, 32'd0);
      checkOutput("rstFault", {31'd0, fetch_fault}, 32'd0);

      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("firstReq", {31'd0, imem_req}, 32'd1);
      checkOutput("pcPlus4AtZero", pc_plus4, 32'd4);

      // Sequential fetch 0, 4, 8
      serveFetch(32'd0);
      applyStimulus(2'd2, 2'd0, 16'd0, 26'd0, 32'd0, 1'b0);
      checkOutput("seqPc4", pc, 32'd4);
      serveFetch(32'd4);
      applyStimulus(2'd2, 2'd0, 16'd0, 26'd0, 32'd0, 1'b0);
      serveFetch(32'd8);

      // Stall: ready low for 5 cycles
      heldInstr = instr;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stallValid", {31'd0, instr_valid}, 32'd1);
         checkOutput("stallInstr", instr, heldInstr);
         checkOutput("stallPc", pc, 32'd8);
         checkOutput("stallNoReq", {31'd0, imem_req}, 32'd0);
      end
      applyStimulus(2'd2, 2'd0, 16'd0, 26'd0, 32'd0, 1'b0);
      checkOutput("reqAfterReady", {31'd0, imem_req}, 32'd1);
      checkOutput("pcAfterReady", pc, 32'h0000_000C);
      curPc = 32'h0000_000C;

      // Next-PC table
      for (int v = 0; v < 10; v++) begin
         serveFetch(curPc);
         applyStimulus(2'd0, 2'd0, 16'd0, 26'd0, vecs[v].startPc, 1'b0);
         checkOutput($sformatf("startPc%0d", v), pc, vecs[v].startPc);
         serveFetch(vecs[v].startPc);
         applyStimulus(vecs[v].jSel, vecs[v].pcSel, vecs[v].imm, vecs[v].jumpAddr,
                       vecs[v].rsData, vecs[v].aluZero);
         checkOutput($sformatf("nextPc%0d", v), pc, vecs[v].expPc);
         checkOutput($sformatf("nextAddr%0d", v), imem_addr, vecs[v].expPc);
         curPc = vecs[v].expPc;
      end

      // Timeout: FETCH + 4 WAIT cycles requesting, 1 gap cycle, then re-request
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 6) imem_ack = 1'b0;
         checkOutput($sformatf("toReq%0d", i), {31'd0, imem_req}, (i == 5) ? 32'd0 : 32'd1);
         checkOutput($sformatf("toAddr%0d", i), imem_addr, curPc);
         checkOutput($sformatf("toValid%0d", i), {31'd0, instr_valid}, 32'd0);
         if (i == 5) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
         end
      end

      // Asynchronous reset mid-WAIT
      #2 rst_n = 1'b0;
      #1;
      checkOutput("asyncRstReq", {31'd0, imem_req}, 32'd0);
      checkOutput("asyncRstPc", pc, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("resumeReq", {31'd0, imem_req}, 32'd1);
      checkOutput("resumeAddr", imem_addr, 32'd0);

      // Misaligned JR target
      serveFetch(32'd0);
      applyStimulus(2'd0, 2'd0, 16'd0, 26'd0, 32'h0000_0202, 1'b0);
`ifdef IFETCH_MISALIGN_TRAP_EN
      checkOutput("trapFault", {31'd0, fetch_fault}, 32'd1);
      checkOutput("trapPc", pc, 32'h0000_0202);
      for (int i = 0; i < 3; i++) begin
         checkOutput("trapNoReq", {31'd0, imem_req}, 32'd0);
         checkOutput("trapValid", {31'd0, instr_valid}, 32'd0);
         @(negedge clk);
      end
`else
      checkOutput("alignPc", pc, 32'h0000_0200);
      checkOutput("alignFault", {31'd0, fetch_fault}, 32'd0);
      serveFetch(32'h0000_0200);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
